// File: rtl/imem_boot_loader.sv
// Boot-time instruction-memory loader: assembles a little-endian byte stream into words,
// writes them to IMEM, verifies a trailing checksum and then releases the core from reset.
module imem_boot_loader #(
    parameter int IMEM_WORDS     = 256,
    parameter int RELEASE_CYCLES = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    input  logic        reload,
    output logic        imem_we,
    output logic [31:0] imem_addr,
    output logic [31:0] imem_wdata,
    output logic        cpu_reset,
    output logic        done,
    output logic        error,
    output logic [1:0]  error_code
);

    localparam int IDX_W = $clog2(IMEM_WORDS + 1);
    localparam int RC_W  = (RELEASE_CYCLES > 1) ? $clog2(RELEASE_CYCLES) : 1;

    typedef enum logic [2:0] {
        ST_HDR,
        ST_DATA,
        ST_CSUM,
        ST_RELEASE,
        ST_RUN,
        ST_ERROR
    } state_t;

    state_t            state_q;
    logic [1:0]        byteCnt_q;
    logic [23:0]       partial_q;
    logic [IDX_W-1:0]  idx_q;
    logic [IDX_W-1:0]  len_q;
    logic [31:0]       sum_q;
    logic [RC_W-1:0]   relCnt_q;
    logic              imemWe_q;
    logic [31:0]       imemAddr_q;
    logic [31:0]       imemWdata_q;
    logic              cpuReset_q;
    logic              done_q;
    logic              error_q;
    logic [1:0]        errorCode_q;

    logic              streamState;
    logic              accept;
    logic              wordDone;
    logic [31:0]       fullWord;

    assign streamState = (state_q == ST_HDR) || (state_q == ST_DATA) || (state_q == ST_CSUM);
    assign in_ready    = !reset && streamState;
    assign accept      = in_valid && in_ready;
    assign wordDone    = accept && (byteCnt_q == 2'd3);
    // The fourth byte is combined straight from the bus so the word completes on its own edge.
    assign fullWord    = {in_data, partial_q};

    assign imem_we    = imemWe_q;
    assign imem_addr  = imemAddr_q;
    assign imem_wdata = imemWdata_q;
    assign cpu_reset  = cpuReset_q;
    assign done       = done_q;
    assign error      = error_q;
    assign error_code = errorCode_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_HDR;
            byteCnt_q   <= 2'd0;
            partial_q   <= 24'd0;
            idx_q       <= '0;
            len_q       <= '0;
            sum_q       <= 32'd0;
            relCnt_q    <= '0;
            imemWe_q    <= 1'b0;
            imemAddr_q  <= 32'd0;
            imemWdata_q <= 32'd0;
            cpuReset_q  <= 1'b1;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            errorCode_q <= 2'b00;
        end else begin
            imemWe_q <= 1'b0;

            if (accept) begin
                byteCnt_q <= byteCnt_q + 2'd1;
                case (byteCnt_q)
                    2'd0:    partial_q[7:0]   <= in_data;
                    2'd1:    partial_q[15:8]  <= in_data;
                    2'd2:    partial_q[23:16] <= in_data;
                    default: ;
                endcase
            end

            case (state_q)
                ST_HDR: begin
                    if (wordDone) begin
                        if ((fullWord == 32'd0) || (fullWord > 32'(IMEM_WORDS))) begin
                            state_q     <= ST_ERROR;
                            error_q     <= 1'b1;
                            errorCode_q <= 2'b01;
                        end else begin
                            state_q <= ST_DATA;
                            len_q   <= fullWord[IDX_W-1:0];
                            idx_q   <= '0;
                            sum_q   <= 32'd0;
                        end
                    end
                end
                ST_DATA: begin
                    if (wordDone) begin
                        imemWe_q    <= 1'b1;
                        imemAddr_q  <= 32'(idx_q) << 2;
                        imemWdata_q <= fullWord;
                        sum_q       <= sum_q + fullWord;
                        idx_q       <= idx_q + IDX_W'(1);
                        if ((idx_q + IDX_W'(1)) == len_q) begin
                            state_q <= ST_CSUM;
                        end
                    end
                end
                ST_CSUM: begin
                    if (wordDone) begin
                        if (fullWord == sum_q) begin
                            state_q  <= ST_RELEASE;
                            relCnt_q <= '0;
                        end else begin
                            state_q     <= ST_ERROR;
                            error_q     <= 1'b1;
                            errorCode_q <= 2'b10;
                        end
                    end
                end
                ST_RELEASE: begin
                    if (relCnt_q == RC_W'(RELEASE_CYCLES - 1)) begin
                        state_q    <= ST_RUN;
                        cpuReset_q <= 1'b0;
                        done_q     <= 1'b1;
                    end else begin
                        relCnt_q <= relCnt_q + RC_W'(1);
                    end
                end
                ST_RUN: begin
                    // Old IMEM contents are left in place; the next image simply overwrites them.
                    if (reload) begin
                        state_q    <= ST_HDR;
                        cpuReset_q <= 1'b1;
                        done_q     <= 1'b0;
                        byteCnt_q  <= 2'd0;
                        idx_q      <= '0;
                        sum_q      <= 32'd0;
                        relCnt_q   <= '0;
                    end
                end
                ST_ERROR: ;
                default: state_q <= ST_HDR;
            endcase
        end
    end

endmodule
